ysyx_25020047_lsu: RTL and testbench
====================================

Name: ysyx_25020047_lsu

Overview:
Load/store unit sitting directly downstream of the EXU in the NPC core. It consumes the EXU's one-hot instruction type, ALU result (effective address) and store data, and performs at most one memory transaction per instruction over a valid/ready request plus response-valid memory port. It delivers write-back data to the WBU through a valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in REQ+WAIT before aborting with bus error; 0 disables the timeout

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  EXU presents an instruction
in_ready  output  1  LSU can accept (high only in IDLE)
in_inst_type  input  32  one-hot type; lw=0x20, lbu=0x40, sw=0x80, sb=0x100
in_result  input  32  ALU result / effective address
in_store_data  input  32  rs2 value for stores
in_reg_wen  input  1  EXU write-back enable
in_rd  input  5  destination register
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_addr  output  32  word-aligned address
mem_wen  output  1  1=write, 0=read
mem_wdata  output  32  lane-replicated store data
mem_wmask  output  4  byte-lane write mask
mem_rsp_valid  input  1  read data / write ack valid
mem_rdata  input  32  read word
out_valid  output  1  write-back packet valid
out_ready  input  1  WBU accepts packet
out_wb_data  output  32  write-back value
out_reg_wen  output  1  register write enable to WBU
out_rd  output  5  destination register
out_misalign  output  1  misaligned lw/sw flagged
out_bus_err  output  1  memory timeout flagged

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. All state, including the FSM, advances on the rising edge of clk.
- Reset: FSM=IDLE; every output 0 except in_ready=1; timeout counter=0. Reset mid-transaction aborts it silently. A later mem_rsp_valid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: in_ready=1. When in_valid=1, latch all in_* fields.
  - Mem op means exactly one of bits {5,6,7,8} is set and no other bit is set. Mem op goes to REQ.
  - lw/sw with in_result[1:0]!=0 goes to DONE with out_misalign=1, out_reg_wen=0 and no memory access.
  - Anything else goes to DONE with out_wb_data=in_result and out_reg_wen=in_reg_wen.
- REQ: mem_req_valid=1. mem_addr={addr[31:2],2'b00}. mem_wen=1 for sw/sb. mem_addr, mem_wen, mem_wdata and mem_wmask are held stable until mem_req_ready. On mem_req_ready go to WAIT.
- WAIT: mem_req_valid=0. On mem_rsp_valid go to DONE.
  - lw: wb_data=mem_rdata.
  - lbu: wb_data = zero-extended byte lane addr[1:0] (lane 0 = bits 7:0).
  - Stores: out_reg_wen=0; the response is a write ack and its data is ignored.
  - mem_rsp_valid outside WAIT is ignored.
- Store encoding:
  - sw: wmask=4'hF, wdata=store_data.
  - sb: wmask=4'b0001<<addr[1:0], wdata={4{store_data[7:0]}}.
- DONE: out_valid=1 with stable packet. On out_ready go to IDLE; the next instruction is not accepted in that same cycle.
- Timeout: the counter runs in REQ+WAIT and clears on entry to REQ. When the count reaches TIMEOUT_CYCLES (if nonzero), go to DONE with out_bus_err=1, out_reg_wen=0, and drop mem_req_valid.
- Latency:
  - Non-mem: accepted at edge N, out_valid from N+1.
  - Mem with ready and response each one cycle after asserting: accept N, REQ N+1, WAIT N+2, out_valid N+3.
- out_misalign and out_bus_err are valid only with out_valid and are cleared on leaving DONE.

Test Plan:
- addi passthrough: type=0x1, result=0x1234, reg_wen=1, rd=5 -> next cycle out_valid=1, wb_data=0x1234, reg_wen=1, rd=5; no mem_req_valid ever.
- lbu lane select: addr=0x80000003, mem_rdata=0xAABBCCDD -> mem_addr=0x80000000, mem_wen=0, out_wb_data=0x000000AA.
- sb: addr=0x80000102, store_data=0x123456EF -> mem_wmask=4'b0100, mem_wdata=0xEFEFEFEF, mem_wen=1, out_reg_wen=0; mem_req_ready held low 3 cycles -> request fields stable throughout.
- Misaligned lw: addr=0x80000002 -> no mem_req_valid, out_misalign=1, out_reg_wen=0.
- Timeout with TIMEOUT_CYCLES=4: lw, mem_req_ready=1, never respond -> out_bus_err=1 after 4 cycles in REQ+WAIT; out_ready held low 2 cycles -> packet stable, in_ready=0.
- Reset in WAIT, then mem_rsp_valid pulses after reset -> IDLE, out_valid stays 0, in_ready=1.

Source files
------------

// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: load/store unit between EXU and WBU.
// Takes one instruction at a time from the EXU, performs at most one
// memory transaction over a valid/ready request port with a separate
// response-valid strobe, and hands a write-back packet to the WBU.
// Non-memory instructions reach the WBU one cycle after acceptance.
// Every output is driven straight from a flop.

module ysyx_25020047_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // EXU side
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst_type,
    input  logic [31:0] in_result,
    input  logic [31:0] in_store_data,
    input  logic        in_reg_wen,
    input  logic [4:0]  in_rd,
    // memory request channel
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    // memory response channel
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    // WBU side
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_wb_data,
    output logic        out_reg_wen,
    output logic [4:0]  out_rd,
    output logic        out_misalign,
    output logic        out_bus_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] TYPE_LW       = 32'h0000_0020;
    localparam logic [31:0] TYPE_LBU      = 32'h0000_0040;
    localparam logic [31:0] TYPE_SW       = 32'h0000_0080;
    localparam logic [31:0] TYPE_SB       = 32'h0000_0100;
    localparam logic [31:0] MEM_TYPE_MASK = 32'h0000_01E0;

    // Counter is just wide enough to hold TIMEOUT_CYCLES.
    localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    // A memory op has exactly one of bits 5..8 set and nothing else.
    function automatic logic is_mem_op(input logic [31:0] t);
        logic one_hot;
        case (t[8:5])
            4'b0001, 4'b0010, 4'b0100, 4'b1000: one_hot = 1'b1;
            default:                            one_hot = 1'b0;
        endcase
        return one_hot && ((t & ~MEM_TYPE_MASK) == 32'h0000_0000);
    endfunction

    // Word ops must sit on a 4-byte boundary; byte ops never misalign.
    function automatic logic is_misaligned(input logic [31:0] t, input logic [1:0] off);
        return ((t == TYPE_LW) || (t == TYPE_SW)) && (off != 2'b00);
    endfunction

    function automatic logic is_store(input logic [31:0] t);
        return (t == TYPE_SW) || (t == TYPE_SB);
    endfunction

    // Byte-lane write mask for the store flavour; loads write nothing.
    function automatic logic [3:0] store_mask(input logic [31:0] t, input logic [1:0] off);
        logic [3:0] m;
        if (t == TYPE_SW) begin
            m = 4'hF;
        end else if (t == TYPE_SB) begin
            m = 4'b0001 << off;
        end else begin
            m = 4'h0;
        end
        return m;
    endfunction

    // sb replicates its byte on every lane so the mask alone selects it.
    function automatic logic [31:0] store_wdata(input logic [31:0] t, input logic [31:0] sd);
        logic [31:0] d;
        if (t == TYPE_SW) begin
            d = sd;
        end else if (t == TYPE_SB) begin
            d = {4{sd[7:0]}};
        end else begin
            d = 32'h0000_0000;
        end
        return d;
    endfunction

    // Zero-extended byte from lane off (lane 0 = bits 7:0).
    function automatic logic [31:0] load_byte(input logic [31:0] w, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            2'd3:    b = w[31:24];
            default: b = 8'h00;
        endcase
        return {24'h00_0000, b};
    endfunction

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [31:0]      type_r;
    logic [1:0]       off_r;
    logic             reg_wen_r;
    logic [4:0]       rd_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             timeout_hit_s;
    logic             in_mem_op_s;
    logic             in_misalign_s;
    logic             go_req_s;

    logic             in_ready_r;
    logic             mem_req_valid_r;
    logic [31:0]      mem_addr_r;
    logic             mem_wen_r;
    logic [31:0]      mem_wdata_r;
    logic [3:0]       mem_wmask_r;
    logic             out_valid_r;
    logic [31:0]      out_wb_data_r;
    logic             out_reg_wen_r;
    logic             out_misalign_r;
    logic             out_bus_err_r;

    assign in_mem_op_s   = is_mem_op(in_inst_type);
    assign in_misalign_s = is_misaligned(in_inst_type, in_result[1:0]);
    assign go_req_s      = in_mem_op_s && !in_misalign_s;
    assign cnt_inc_s     = cnt_r + CNT_W'(1);
    assign timeout_hit_s = TIMEOUT_EN && (cnt_inc_s == CNT_LIMIT);

    // Next-state: in REQ the timeout beats a late grant; in WAIT a response beats the timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    if (go_req_s) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else if (mem_req_ready) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rsp_valid) begin
                    state_nxt_s = ST_DONE;
                end else if (timeout_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, handshake flags, latched instruction and the outgoing packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            type_r          <= 32'h0000_0000;
            off_r           <= 2'b00;
            reg_wen_r       <= 1'b0;
            rd_r            <= 5'd0;
            cnt_r           <= '0;
            in_ready_r      <= 1'b1;
            mem_req_valid_r <= 1'b0;
            mem_addr_r      <= 32'h0000_0000;
            mem_wen_r       <= 1'b0;
            mem_wdata_r     <= 32'h0000_0000;
            mem_wmask_r     <= 4'h0;
            out_valid_r     <= 1'b0;
            out_wb_data_r   <= 32'h0000_0000;
            out_reg_wen_r   <= 1'b0;
            out_misalign_r  <= 1'b0;
            out_bus_err_r   <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            in_ready_r      <= (state_nxt_s == ST_IDLE);
            mem_req_valid_r <= (state_nxt_s == ST_REQ);
            out_valid_r     <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        type_r      <= in_inst_type;
                        off_r       <= in_result[1:0];
                        reg_wen_r   <= in_reg_wen;
                        rd_r        <= in_rd;
                        cnt_r       <= '0;
                        // Request fields are fixed here and stay put until granted.
                        mem_addr_r  <= {in_result[31:2], 2'b00};
                        mem_wen_r   <= is_store(in_inst_type);
                        mem_wdata_r <= store_wdata(in_inst_type, in_store_data);
                        mem_wmask_r <= store_mask(in_inst_type, in_result[1:0]);
                        if (!go_req_s) begin
                            out_wb_data_r  <= in_misalign_s ? 32'h0000_0000 : in_result;
                            out_reg_wen_r  <= in_misalign_s ? 1'b0 : in_reg_wen;
                            out_misalign_r <= in_misalign_s;
                        end else begin
                            out_misalign_r <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    cnt_r <= TIMEOUT_EN ? cnt_inc_s : cnt_r;
                    if ((state_r == ST_WAIT) && mem_rsp_valid) begin
                        if (type_r == TYPE_LW) begin
                            out_wb_data_r <= mem_rdata;
                            out_reg_wen_r <= reg_wen_r;
                        end else if (type_r == TYPE_LBU) begin
                            out_wb_data_r <= load_byte(mem_rdata, off_r);
                            out_reg_wen_r <= reg_wen_r;
                        end else begin
                            // Store ack: its data carries nothing.
                            out_wb_data_r <= 32'h0000_0000;
                            out_reg_wen_r <= 1'b0;
                        end
                    end else if (timeout_hit_s) begin
                        out_wb_data_r <= 32'h0000_0000;
                        out_reg_wen_r <= 1'b0;
                        out_bus_err_r <= 1'b1;
                    end else begin
                        out_bus_err_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_reg_wen_r  <= 1'b0;
                        out_misalign_r <= 1'b0;
                        out_bus_err_r  <= 1'b0;
                    end else begin
                        out_bus_err_r  <= out_bus_err_r;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign in_ready      = in_ready_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wen       = mem_wen_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wmask     = mem_wmask_r;
    assign out_valid     = out_valid_r;
    assign out_wb_data   = out_wb_data_r;
    assign out_reg_wen   = out_reg_wen_r;
    assign out_rd        = rd_r;
    assign out_misalign  = out_misalign_r;
    assign out_bus_err   = out_bus_err_r;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// Scoreboard bench for ysyx_25020047_lsu. Two instances share the input
// pins: one with the default timeout and one with TIMEOUT_CYCLES=4; use_to
// routes in_valid and the observed outputs to the instance under test.
// A memory responder checks request fields and answers; a monitor checks
// every presented write-back packet against the expected queue.

module tb_ysyx_25020047_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        use_to = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst_type = 32'h0;
    logic [31:0] in_result = 32'h0;
    logic [31:0] in_store_data = 32'h0;
    logic        in_reg_wen = 1'b0;
    logic [4:0]  in_rd = 5'd0;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_ready = 1'b1;

    logic        a_in_ready, b_in_ready, a_mem_req_valid, b_mem_req_valid;
    logic [31:0] a_mem_addr, b_mem_addr, a_mem_wdata, b_mem_wdata;
    logic        a_mem_wen, b_mem_wen, a_out_valid, b_out_valid;
    logic [3:0]  a_mem_wmask, b_mem_wmask;
    logic [31:0] a_out_wb_data, b_out_wb_data;
    logic        a_out_reg_wen, b_out_reg_wen, a_out_misalign, b_out_misalign;
    logic        a_out_bus_err, b_out_bus_err;
    logic [4:0]  a_out_rd, b_out_rd;

    logic        in_ready, mem_req_valid, mem_wen, out_valid, out_reg_wen, out_misalign, out_bus_err;
    logic [31:0] mem_addr, mem_wdata, out_wb_data;
    logic [3:0]  mem_wmask;
    logic [4:0]  out_rd;

    assign in_ready      = use_to ? b_in_ready      : a_in_ready;
    assign mem_req_valid = use_to ? b_mem_req_valid : a_mem_req_valid;
    assign mem_addr      = use_to ? b_mem_addr      : a_mem_addr;
    assign mem_wen       = use_to ? b_mem_wen       : a_mem_wen;
    assign mem_wdata     = use_to ? b_mem_wdata     : a_mem_wdata;
    assign mem_wmask     = use_to ? b_mem_wmask     : a_mem_wmask;
    assign out_valid     = use_to ? b_out_valid     : a_out_valid;
    assign out_wb_data   = use_to ? b_out_wb_data   : a_out_wb_data;
    assign out_reg_wen   = use_to ? b_out_reg_wen   : a_out_reg_wen;
    assign out_rd        = use_to ? b_out_rd        : a_out_rd;
    assign out_misalign  = use_to ? b_out_misalign  : a_out_misalign;
    assign out_bus_err   = use_to ? b_out_bus_err   : a_out_bus_err;

    ysyx_25020047_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !use_to), .in_ready(a_in_ready),
        .in_inst_type(in_inst_type), .in_result(in_result), .in_store_data(in_store_data),
        .in_reg_wen(in_reg_wen), .in_rd(in_rd),
        .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(a_mem_addr), .mem_wen(a_mem_wen), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_wb_data(a_out_wb_data),
        .out_reg_wen(a_out_reg_wen), .out_rd(a_out_rd),
        .out_misalign(a_out_misalign), .out_bus_err(a_out_bus_err)
    );

    ysyx_25020047_lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && use_to), .in_ready(b_in_ready),
        .in_inst_type(in_inst_type), .in_result(in_result), .in_store_data(in_store_data),
        .in_reg_wen(in_reg_wen), .in_rd(in_rd),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(b_mem_addr), .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_wb_data(b_out_wb_data),
        .out_reg_wen(b_out_reg_wen), .out_rd(b_out_rd),
        .out_misalign(b_out_misalign), .out_bus_err(b_out_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    typedef struct {
        logic [31:0] wb;
        logic        chk_wb;
        logic        reg_wen;
        logic [4:0]  rd;
        logic        mis;
        logic        berr;
    } pkt_t;

    req_t req_q[$];
    pkt_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // responder controls
    int          stall_cfg = 0;
    int          stall_cnt = 0;
    bit          rsp_enable = 1'b1;
    logic [31:0] rsp_data = 32'h0;
    int          force_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
        req_t r;
        r.addr = a; r.wen = w; r.wdata = d; r.wmask = m;
        req_q.push_back(r);
    endtask

    task automatic push_pkt(input logic [31:0] wb, input logic cw, input logic wen,
                            input logic [4:0] rd, input logic mis, input logic berr);
        pkt_t p;
        p.wb = wb; p.chk_wb = cw; p.reg_wen = wen; p.rd = rd; p.mis = mis; p.berr = berr;
        exp_q.push_back(p);
    endtask

    // Memory model: checks request fields every cycle they are offered,
    // grants after stall_cfg cycles and responds the cycle after the grant.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 32'h0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            if (force_pulses > 0) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = 32'hDEAD_BEEF;
                force_pulses--;
            end else if (mem_req_ready && rsp_enable) begin
                mem_rsp_valid = 1'b1;
                mem_rdata     = rsp_data;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got addr 0x%08h expected no request at %0t", mem_addr, $time);
                end else begin
                    chk("req_addr", mem_addr, req_q[0].addr);
                    chk("req_wen", {31'b0, mem_wen}, {31'b0, req_q[0].wen});
                    if (req_q[0].wen) begin
                        chk("req_wdata", mem_wdata, req_q[0].wdata);
                        chk("req_wmask", {28'b0, mem_wmask}, {28'b0, req_q[0].wmask});
                    end
                    if (stall_cnt < stall_cfg) begin
                        stall_cnt++;
                    end else begin
                        mem_req_ready = 1'b1;
                        stall_cnt     = 0;
                        void'(req_q.pop_front());
                    end
                end
            end
        end
    end

    // Monitor: compare every presented packet; while stalled it must hold and block new input.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pkt: got wb 0x%08h rd %0d expected no packet at %0t", out_wb_data, out_rd, $time);
            end else begin
                if (exp_q[0].chk_wb) chk("wb_data", out_wb_data, exp_q[0].wb);
                chk("reg_wen", {31'b0, out_reg_wen}, {31'b0, exp_q[0].reg_wen});
                chk("rd", {27'b0, out_rd}, {27'b0, exp_q[0].rd});
                chk("misalign", {31'b0, out_misalign}, {31'b0, exp_q[0].mis});
                chk("bus_err", {31'b0, out_bus_err}, {31'b0, exp_q[0].berr});
                if (!out_ready) begin
                    chk("in_ready_in_done", {31'b0, in_ready}, 32'h0);
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [31:0] t, input logic [31:0] r, input logic [31:0] sd,
                         input logic wen, input logic [4:0] rd);
        int n = 0;
        @(posedge clk); #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("issue_ready", {31'b0, in_ready}, 32'h1);
        in_valid = 1'b1; in_inst_type = t; in_result = r;
        in_store_data = sd; in_reg_wen = wen; in_rd = rd;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_latency(input string name, input int exp_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 40);
        chk(name, 32'(n), 32'(exp_cyc));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && req_q.size() == 0 && in_ready) && n < 60);
        chk("reach_idle", {31'b0, (exp_q.size() == 0 && req_q.size() == 0 && in_ready)}, 32'h1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_wb_data", out_wb_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_wmask", {28'b0, mem_wmask}, 32'h0);
        chk("rst_flags", {30'b0, out_misalign, out_bus_err}, 32'h0);

        // addi passthrough
        push_pkt(32'h0000_1234, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
        issue(32'h1, 32'h0000_1234, 32'h0, 1'b1, 5'd5);
        expect_latency("lat_addi", 1);
        wait_idle();

        // lbu from lane 3
        rsp_data = 32'hAABB_CCDD;
        push_req(32'h8000_0000, 1'b0, 32'h0, 4'h0);
        push_pkt(32'h0000_00AA, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
        issue(32'h40, 32'h8000_0003, 32'h0, 1'b1, 5'd7);
        expect_latency("lat_lbu", 3);
        wait_idle();

        // sb lane 2 with three stalled grant cycles
        stall_cfg = 3;
        push_req(32'h8000_0100, 1'b1, 32'hEFEF_EFEF, 4'b0100);
        push_pkt(32'h0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
        issue(32'h100, 32'h8000_0102, 32'h1234_56EF, 1'b1, 5'd9);
        wait_idle();
        stall_cfg = 0;

        // aligned lw
        rsp_data = 32'hCAFE_F00D;
        push_req(32'h8000_0010, 1'b0, 32'h0, 4'h0);
        push_pkt(32'hCAFE_F00D, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
        issue(32'h20, 32'h8000_0010, 32'h0, 1'b1, 5'd1);
        expect_latency("lat_lw", 3);
        wait_idle();

        // aligned sw
        push_req(32'h8000_0020, 1'b1, 32'h1122_3344, 4'hF);
        push_pkt(32'h0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
        issue(32'h80, 32'h8000_0020, 32'h1122_3344, 1'b1, 5'd2);
        wait_idle();

        // misaligned lw: no memory access
        push_pkt(32'h0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        issue(32'h20, 32'h8000_0002, 32'h0, 1'b1, 5'd3);
        expect_latency("lat_misalign", 1);
        wait_idle();

        // two memory bits set is not a memory op
        push_pkt(32'h8000_0004, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0);
        issue(32'h60, 32'h8000_0004, 32'h0, 1'b0, 5'd4);
        expect_latency("lat_twobit", 1);
        wait_idle();

        // timeout on the TIMEOUT_CYCLES=4 instance, WBU stalls the packet
        use_to = 1'b1;
        rsp_enable = 1'b0;
        out_ready = 1'b0;
        push_req(32'h8000_0040, 1'b0, 32'h0, 4'h0);
        push_pkt(32'h0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1);
        issue(32'h20, 32'h8000_0040, 32'h0, 1'b1, 5'd6);
        expect_latency("lat_timeout", 5);
        chk("timeout_req_dropped", {31'b0, mem_req_valid}, 32'h0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle();
        chk("bus_err_cleared", {31'b0, out_bus_err}, 32'h0);
        use_to = 1'b0;

        // reset while waiting for a response, then stray responses
        push_req(32'h8000_0050, 1'b0, 32'h0, 4'h0);
        issue(32'h20, 32'h8000_0050, 32'h0, 1'b1, 5'd8);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        force_pulses = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw_out_valid", {31'b0, out_valid}, 32'h0);
            chk("rstw_in_ready", {31'b0, in_ready}, 32'h1);
            chk("rstw_req_valid", {31'b0, mem_req_valid}, 32'h0);
        end
        rsp_enable = 1'b1;

        // recovery after the abort
        push_pkt(32'h0000_0055, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0);
        issue(32'h1, 32'h0000_0055, 32'h0, 1'b1, 5'd31);
        expect_latency("lat_recover", 1);
        wait_idle();
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("req_q_drained", 32'(req_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
